// File: rtl/cpu_core_param.sv
// cpu_core_param: handshaked accumulator CPU with a parametrised data width and memory depth.
// A command is taken on cmd_valid & cpu_rdy and executed by a multi-cycle FSM
// (IDLE/EXEC/MULT/MEMRD/WB). The result is written to a 2*WIDTH accumulator with
// registered zero/error flags, and result_valid pulses for one cycle during WB.
// The optional iterative shift-add multiplier is enabled by defining CPU_MUL_EN.
// Without it, opcode 010 sets error and leaves the accumulator unchanged.
// MEM_DEPTH is expected to be a power of two with $clog2(MEM_DEPTH) <= WIDTH.
module cpu_core_param #(
  parameter int WIDTH     = 8,
  parameter int MEM_DEPTH = 256
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [6:0]         cmd_in,
  input  logic               cmd_valid,
  input  logic [WIDTH-1:0]   din_1,
  input  logic [WIDTH-1:0]   din_2,
  input  logic [WIDTH-1:0]   din_3,
  output logic               cpu_rdy,
  output logic [2*WIDTH-1:0] result,
  output logic               result_valid,
  output logic               zero,
  output logic               error
);
  localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int RW = 2 * WIDTH;

  localparam logic [2:0] OP_ADD   = 3'd0;
  localparam logic [2:0] OP_SUB   = 3'd1;
  localparam logic [2:0] OP_MUL   = 3'd2;
  localparam logic [2:0] OP_AND   = 3'd3;
  localparam logic [2:0] OP_OR    = 3'd4;
  localparam logic [2:0] OP_XOR   = 3'd5;
  localparam logic [2:0] OP_LOAD  = 3'd6;
  localparam logic [2:0] OP_STORE = 3'd7;

  typedef enum logic [2:0] {S_IDLE, S_EXEC, S_MULT, S_MEMRD, S_WB} state_t;

  state_t           r_state, w_next;
  logic [2:0]       r_op;
  logic [WIDTH-1:0] r_a, r_b;
  logic [AW-1:0]    r_addr;
  logic [RW-1:0]    r_acc, r_rdata;
  logic             r_zero, r_err;
  logic [RW-1:0]    r_mem [MEM_DEPTH];

  logic             w_idle, w_hs;
  logic [WIDTH-1:0] w_opa, w_opb;
  logic [RW-1:0]    w_alu, w_wb_val;
  logic             w_alu_err, w_wb_err;

  assign w_idle  = (r_state == S_IDLE);
  // cpu_rdy is masked by reset so no command can slip in while reset is held
  assign cpu_rdy = w_idle & ~reset;
  assign w_hs    = cmd_valid & cpu_rdy;

  assign result       = r_acc;
  assign zero         = r_zero;
  assign error        = r_err;
  assign result_valid = (r_state == S_WB);

  // operand select: 00 din_1, 01 din_2, 10 din_3, 11 low half of the accumulator
  always_comb begin
    w_opa = din_1;
    w_opb = din_1;
    case (cmd_in[3:2])
      2'd0:    w_opa = din_1;
      2'd1:    w_opa = din_2;
      2'd2:    w_opa = din_3;
      default: w_opa = r_acc[WIDTH-1:0];
    endcase
    case (cmd_in[1:0])
      2'd0:    w_opb = din_1;
      2'd1:    w_opb = din_2;
      2'd2:    w_opb = din_3;
      default: w_opb = r_acc[WIDTH-1:0];
    endcase
  end

  // capture the command and operands on handshake; later input changes are ignored
  always_ff @(posedge clk) begin
    if (w_hs) begin
      r_op   <= cmd_in[6:4];
      r_a    <= w_opa;
      r_b    <= w_opb;
      r_addr <= din_1[AW-1:0];
    end
  end

  // single-cycle ALU evaluated from the captured operands during EXEC
  always_comb begin
    w_alu     = r_acc;
    w_alu_err = 1'b0;
    case (r_op)
      OP_ADD: w_alu = RW'(r_a) + RW'(r_b);
      OP_SUB: begin
        w_alu     = RW'(r_a) - RW'(r_b);
        w_alu_err = (r_a < r_b);
      end
      OP_AND: w_alu = RW'(r_a & r_b);
      OP_OR:  w_alu = RW'(r_a | r_b);
      OP_XOR: w_alu = RW'(r_a ^ r_b);
`ifndef CPU_MUL_EN
      // no multiplier: accumulator is kept and the command is flagged as an error
      OP_MUL: w_alu_err = 1'b1;
`endif
      default: ;
    endcase
  end

`ifdef CPU_MUL_EN
  localparam int CW = $clog2(WIDTH + 1);
  logic [RW-1:0]    r_mcand, r_prod, w_prod_nxt;
  logic [WIDTH-1:0] r_mplier;
  logic [CW-1:0]    r_cnt;

  // the final partial product is folded into the writeback value, so MULT takes exactly WIDTH cycles
  assign w_prod_nxt = r_prod + (r_mplier[0] ? r_mcand : '0);

  // shift-add multiplier: seeded in EXEC, then one multiplier bit per MULT cycle
  always_ff @(posedge clk) begin
    if (r_state == S_EXEC) begin
      r_prod   <= '0;
      r_mcand  <= RW'(r_a);
      r_mplier <= r_b;
      r_cnt    <= '0;
    end else if (r_state == S_MULT) begin
      r_prod   <= w_prod_nxt;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + 1'b1;
    end
  end
`endif

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // FSM next state
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_hs) w_next = S_EXEC;
      S_EXEC: begin
        case (r_op)
          OP_LOAD:  w_next = S_MEMRD;
          OP_STORE: w_next = S_IDLE;
`ifdef CPU_MUL_EN
          OP_MUL:   w_next = S_MULT;
`endif
          default:  w_next = S_WB;
        endcase
      end
`ifdef CPU_MUL_EN
      S_MULT:  if (r_cnt == CW'(WIDTH - 1)) w_next = S_WB;
`endif
      S_MEMRD: w_next = S_WB;
      S_WB:    w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // choose the writeback source according to the state that is about to enter WB
  always_comb begin
    w_wb_val = w_alu;
    w_wb_err = w_alu_err;
    if (r_state == S_MEMRD) begin
      w_wb_val = r_rdata;
      w_wb_err = 1'b0;
    end
`ifdef CPU_MUL_EN
    if (r_state == S_MULT) begin
      w_wb_val = w_prod_nxt;
      w_wb_err = 1'b0;
    end
`endif
  end

  // accumulator and flags load on the edge entering WB
  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc  <= '0;
      r_zero <= 1'b0;
      r_err  <= 1'b0;
    end else if (w_next == S_WB) begin
      r_acc  <= w_wb_val;
      r_zero <= (w_wb_val == '0);
      r_err  <= w_wb_err;
    end
  end

  // data memory (not reset): STORE is written at the end of EXEC, LOAD data is registered for MEMRD
  always_ff @(posedge clk) begin
    if (!reset && r_state == S_EXEC && r_op == OP_STORE) r_mem[r_addr] <= r_acc;
    if (r_state == S_EXEC && r_op == OP_LOAD) r_rdata <= r_mem[r_addr];
  end

endmodule

// File: tb/tb_cpu_core_param.sv
// Testbench for cpu_core_param. A transaction-level model predicts the accumulator,
// flags, result_valid cycle and cpu_rdy cycle for each accepted command. A compare
// process checks every cycle, and directed literal checks pin the model.
module tb_cpu_core_param;
  localparam int W  = 8;
  localparam int D  = 256;
  localparam int AW = $clog2(D);
  localparam int RW = 2 * W;
`ifdef CPU_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif
  localparam int LAT_MUL = MUL_EN ? W + 2 : 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [6:0]    cmd_in = '0;
  logic          cmd_valid = 1'b0;
  logic [W-1:0]  din_1 = '0, din_2 = '0, din_3 = '0;
  logic          cpu_rdy, result_valid, zero, error;
  logic [RW-1:0] result;

  cpu_core_param #(.WIDTH(W), .MEM_DEPTH(D)) dut (
    .clk(clk), .reset(reset), .cmd_in(cmd_in), .cmd_valid(cmd_valid),
    .din_1(din_1), .din_2(din_2), .din_3(din_3),
    .cpu_rdy(cpu_rdy), .result(result), .result_valid(result_valid),
    .zero(zero), .error(error)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0;
  int cyc = 0;

  // model state
  logic [RW-1:0] m_acc = '0;
  logic          m_zero = 1'b0, m_err = 1'b0;
  logic [RW-1:0] p_acc = '0;
  logic          p_zero = 1'b0, p_err = 1'b0;
  int            p_cyc = -1, st_cyc = -1, rdy_cyc = 0, rv_at = -1;
  logic [AW-1:0] st_addr = '0;
  logic [RW-1:0] st_data = '0;
  int            hs_count = 0, last_hs = -1;
  logic [RW-1:0] mmem [D];
  bit            mval [D];

  logic [W-1:0]  ma, mb;
  logic [RW-1:0] mv;
  logic          me;
  int            mlat;

  function automatic logic [W-1:0] pick(input logic [1:0] s);
    case (s)
      2'd0:    return din_1;
      2'd1:    return din_2;
      2'd2:    return din_3;
      default: return m_acc[W-1:0];
    endcase
  endfunction

  // model: advanced once per rising edge, cyc = index of the cycle that edge ends
  always @(posedge clk) begin
    if (reset) begin
      m_acc = '0; m_zero = 1'b0; m_err = 1'b0;
      p_cyc = -1; st_cyc = -1; rdy_cyc = cyc + 1;
    end else begin
      if (cyc == st_cyc) begin mmem[st_addr] = st_data; mval[st_addr] = 1'b1; end
      if (cyc + 1 == p_cyc) begin
        m_acc = p_acc; m_zero = p_zero; m_err = p_err; rv_at = p_cyc;
      end
      if (cmd_valid && cyc >= rdy_cyc) begin
        hs_count++; last_hs = cyc;
        ma = pick(cmd_in[3:2]); mb = pick(cmd_in[1:0]);
        me = 1'b0; mlat = 2; mv = m_acc;
        case (cmd_in[6:4])
          3'd0: mv = RW'(longint'(ma) + longint'(mb));
          3'd1: begin mv = RW'(longint'(ma) - longint'(mb)); me = (ma < mb); end
          3'd2: if (MUL_EN) begin mv = RW'(longint'(ma) * longint'(mb)); mlat = W + 2; end
                else me = 1'b1;
          3'd3: mv = RW'(ma & mb);
          3'd4: mv = RW'(ma | mb);
          3'd5: mv = RW'(ma ^ mb);
          3'd6: begin mv = mmem[din_1[AW-1:0]]; mlat = 3; end
          default: ;
        endcase
        if (cmd_in[6:4] == 3'd7) begin
          st_cyc = cyc + 1; st_addr = din_1[AW-1:0]; st_data = m_acc;
          rdy_cyc = cyc + 2;
        end else begin
          p_acc = mv; p_zero = (mv == '0); p_err = me;
          p_cyc = cyc + mlat; rdy_cyc = cyc + mlat + 1;
        end
      end
    end
    cyc++;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  // per-cycle comparison of every output against the model
  always @(negedge clk) begin
    if (cyc > 0) begin
      chk("cpu_rdy", 32'(cpu_rdy), 32'(!reset && cyc >= rdy_cyc));
      chk("result_valid", 32'(result_valid), 32'(cyc == rv_at));
      chk("result", 32'(result), 32'(m_acc));
      chk("zero", 32'(zero), 32'(m_zero));
      chk("error", 32'(error), 32'(m_err));
    end
  end

  task automatic tick();
    @(negedge clk); #1;
  endtask

  task automatic wait_cyc(input int n);
    for (int k = 0; k < 1000 && cyc < n; k++) tick();
  endtask

  // hold a command until the model accepts it; returns the handshake cycle
  task automatic issue(input logic [2:0] op, input logic [1:0] sa, input logic [1:0] sb,
                       input logic [W-1:0] d1, input logic [W-1:0] d2, input logic [W-1:0] d3,
                       output int t);
    int n0;
    n0 = hs_count;
    cmd_in = {op, sa, sb}; din_1 = d1; din_2 = d2; din_3 = d3; cmd_valid = 1'b1;
    for (int k = 0; k < 200 && hs_count == n0; k++) tick();
    if (hs_count == n0) begin
      n_chk++; n_err++;
      $display("FAIL handshake_timeout cyc=%0d: got none expected accept", cyc);
      t = cyc;
    end else t = last_hs;
    cmd_valid = 1'b0;
    din_1 = W'($urandom); din_2 = W'($urandom); din_3 = W'($urandom);
    cmd_in = 7'($urandom);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog cyc=%0d: got timeout expected finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t, t2;
    logic [2:0] op;
    logic [W-1:0] d1;
    int a;

    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    tick();
    chk("rst_result", 32'(result), 32'h0);
    chk("rst_zero", 32'(zero), 32'h0);
    chk("rst_error", 32'(error), 32'h0);
    chk("rst_rv", 32'(result_valid), 32'h0);
    chk("rst_rdy", 32'(cpu_rdy), 32'h1);

    // ADD 0xF0 + 0x20
    issue(3'd0, 2'd0, 2'd1, 8'hF0, 8'h20, 8'h00, t);
    chk("add_rv_t1", 32'(result_valid), 32'h0);
    wait_cyc(t + 2);
    chk("add_result", 32'(result), 32'h0110);
    chk("add_zero", 32'(zero), 32'h0);
    chk("add_error", 32'(error), 32'h0);
    chk("add_rv_t2", 32'(result_valid), 32'h1);
    wait_cyc(t + 3);
    chk("add_rv_t3", 32'(result_valid), 32'h0);
    chk("add_rdy_t3", 32'(cpu_rdy), 32'h1);

    // SUB equal and borrowing
    issue(3'd1, 2'd0, 2'd1, 8'h05, 8'h05, 8'h00, t);
    wait_cyc(t + 2);
    chk("sub0_result", 32'(result), 32'h0);
    chk("sub0_zero", 32'(zero), 32'h1);
    issue(3'd1, 2'd0, 2'd1, 8'h03, 8'h05, 8'h00, t);
    wait_cyc(t + 2);
    chk("subneg_result", 32'(result), 32'hFFFE);
    chk("subneg_error", 32'(error), 32'h1);
    chk("subneg_zero", 32'(zero), 32'h0);

    // STORE / LOAD sequence; the second STORE overwrites so a stale LOAD would show 0x0002
    issue(3'd0, 2'd0, 2'd1, 8'h01, 8'h01, 8'h00, t);
    wait_cyc(t + 2);
    issue(3'd7, 2'd0, 2'd0, 8'h2A, 8'h00, 8'h00, t);
    chk("st_rdy_t1", 32'(cpu_rdy), 32'h0);
    wait_cyc(t + 2);
    chk("st_rdy_t2", 32'(cpu_rdy), 32'h1);
    chk("st_rv_t2", 32'(result_valid), 32'h0);
    chk("st_result", 32'(result), 32'h0002);
    issue(3'd0, 2'd0, 2'd1, 8'hF0, 8'h20, 8'h00, t);
    wait_cyc(t + 2);
    issue(3'd7, 2'd0, 2'd0, 8'h2A, 8'h00, 8'h00, t);
    wait_cyc(t + 2);
    issue(3'd6, 2'd0, 2'd0, 8'h2A, 8'h00, 8'h00, t2);
    chk("ld_b2b_accept", 32'(t2), 32'(t + 2));
    wait_cyc(t2 + 2);
    chk("ld_rv_t2", 32'(result_valid), 32'h0);
    wait_cyc(t2 + 3);
    chk("ld_result", 32'(result), 32'h0110);
    chk("ld_rv_t3", 32'(result_valid), 32'h1);
    issue(3'd0, 2'd0, 2'd1, 8'h01, 8'h01, 8'h00, t);
    wait_cyc(t + 2);
    issue(3'd6, 2'd0, 2'd0, 8'h2A, 8'h00, 8'h00, t);
    wait_cyc(t + 3);
    chk("ld2_result", 32'(result), 32'h0110);

    // MUL 0xFF * 0xFF
    issue(3'd2, 2'd0, 2'd0, 8'hFF, 8'h00, 8'h00, t);
    if (MUL_EN) begin
      wait_cyc(t + W + 1);
      chk("mul_rv_early", 32'(result_valid), 32'h0);
      wait_cyc(t + W + 2);
      chk("mul_result", 32'(result), 32'hFE01);
      chk("mul_rv", 32'(result_valid), 32'h1);
      chk("mul_error", 32'(error), 32'h0);
    end else begin
      wait_cyc(t + 2);
      chk("nomul_result", 32'(result), 32'h0110);
      chk("nomul_error", 32'(error), 32'h1);
      chk("nomul_rv", 32'(result_valid), 32'h1);
    end
    wait_cyc(t + LAT_MUL + 1);

    // cmd_valid held through a MUL: next command only in the first IDLE cycle
    issue(3'd2, 2'd1, 2'd2, 8'h00, 8'h03, 8'h05, t);
    cmd_in = {3'd0, 2'd0, 2'd1}; din_1 = 8'h01; din_2 = 8'h02; cmd_valid = 1'b1;
    wait_cyc(t + LAT_MUL);
    chk("held_rdy_wb", 32'(cpu_rdy), 32'h0);
    issue(3'd0, 2'd0, 2'd1, 8'h01, 8'h02, 8'h00, t2);
    chk("held_accept", 32'(t2), 32'(t + LAT_MUL + 1));
    wait_cyc(t2 + 2);
    chk("held_add_result", 32'(result), 32'h0003);

    // reset in cycle T+3 of a MUL aborts it and clears the accumulator
    issue(3'd2, 2'd0, 2'd0, 8'hFF, 8'h00, 8'h00, t);
    wait_cyc(t + 3);
    reset = 1'b1;
    tick();
    chk("abort_result", 32'(result), 32'h0);
    chk("abort_rv", 32'(result_valid), 32'h0);
    chk("abort_rdy_in_rst", 32'(cpu_rdy), 32'h0);
    reset = 1'b0;
    tick();
    chk("abort_rdy", 32'(cpu_rdy), 32'h1);
    chk("abort_result2", 32'(result), 32'h0);

    // randomized commands with occasional reset pulses; the model checks every cycle
    for (int i = 0; i < 400; i++) begin
      op = 3'($urandom_range(0, 7));
      d1 = W'($urandom);
      if (op == 3'd6 || op == 3'd7) begin
        a = $urandom_range(0, 15);
        d1 = W'(a);
        if (op == 3'd6 && !mval[a]) op = 3'd0;
      end
      issue(op, 2'($urandom), 2'($urandom), d1, W'($urandom), W'($urandom), t);
      if ($urandom_range(0, 19) == 0) begin
        repeat ($urandom_range(0, W + 2)) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
      end
      repeat ($urandom_range(0, 2)) tick();
    end
    wait_cyc(cyc + W + 4);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
